// File: rtl/jk_excitation_driver_if.sv
// Pattern handshake, flip-flop feedback and status bundle for jk_excitation_driver.
// The master side is the environment: it offers patterns and returns the external Q.
interface jk_excitation_driver_if #(
    parameter int N = 8
);
    logic [N-1:0] pat;
    logic         pat_valid;
    logic         pat_ready;
    logic         qfb;
    logic         j;
    logic         k;
    logic         busy;
    logic         done;
    logic         err;
    logic [3:0]   errcnt;

    modport master (
        output pat, pat_valid, qfb,
        input  pat_ready, j, k, busy, done, err, errcnt
    );

    modport slave (
        input  pat, pat_valid, qfb,
        output pat_ready, j, k, busy, done, err, errcnt
    );
endinterface

// File: rtl/jk_excitation_driver.sv
// Drives an external JK flip-flop through an N-bit target Q sequence (bit 0 first).
// Each bit takes a DRIVE cycle (J/K chosen from the live Q feedback) followed by a
// CHECK cycle that compares the settled Q against the target and counts mismatches.
module jk_excitation_driver #(
    parameter int N           = 8,
    parameter bit TOGGLE_MODE = 1'b0
) (
    input  logic                   clk,
    input  logic                   reset,
    jk_excitation_driver_if.slave  bus
);
    localparam int IW = $clog2(N);

    typedef enum logic [1:0] {IDLE, DRIVE, CHECK, FIN} state_t;

    state_t         state;
    state_t         state_nxt;
    logic [N-1:0]   shreg;
    logic [IW-1:0]  idx;
    logic           err_q;
    logic [3:0]     errcnt_q;

    logic           tgt;
    logic           mism;
    logic           accept;
    logic           last;
    logic           pat_ready_c;
    logic           busy_c;
    logic           done_c;
    logic           j_c;
    logic           k_c;

    // Mismatch counter stops at 15 rather than wrapping.
    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'd15) ? v : v + 4'd1;
    endfunction

    assign tgt    = shreg[0];
    assign mism   = (bus.qfb != tgt);
    assign accept = (state == IDLE) && bus.pat_valid;
    assign last   = (idx == IW'(N - 1));

    // State register; reset wins over any pattern offered at the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-state outputs; J/K follow Q combinationally only in DRIVE.
    always_comb begin
        state_nxt   = state;
        pat_ready_c = 1'b0;
        busy_c      = 1'b0;
        done_c      = 1'b0;
        j_c         = 1'b0;
        k_c         = 1'b0;
        case (state)
            IDLE: begin
                pat_ready_c = 1'b1;
                if (bus.pat_valid) begin
                    state_nxt = DRIVE;
                end
            end
            DRIVE: begin
                busy_c = 1'b1;
                if (mism) begin
                    if (TOGGLE_MODE) begin
                        j_c = 1'b1;
                        k_c = 1'b1;
                    end else begin
                        j_c = tgt;
                        k_c = ~tgt;
                    end
                end
                state_nxt = CHECK;
            end
            CHECK: begin
                busy_c    = 1'b1;
                state_nxt = last ? FIN : DRIVE;
            end
            FIN: begin
                done_c    = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Pattern shift register: loaded on accept, advanced as each CHECK completes.
    always_ff @(posedge clk) begin
        if (accept) begin
            shreg <= bus.pat;
        end else if (state == CHECK) begin
            shreg <= shreg >> 1;
        end
    end

    // Bit index and error status; status is held after FIN until the next accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx      <= '0;
            err_q    <= 1'b0;
            errcnt_q <= 4'd0;
        end else if (accept) begin
            idx      <= '0;
            err_q    <= 1'b0;
            errcnt_q <= 4'd0;
        end else if (state == CHECK) begin
            if (mism) begin
                err_q    <= 1'b1;
                errcnt_q <= sat_inc(errcnt_q);
            end
            if (!last) begin
                idx <= idx + IW'(1);
            end
        end
    end

    assign bus.pat_ready = pat_ready_c;
    assign bus.busy      = busy_c;
    assign bus.done      = done_c;
    assign bus.j         = j_c;
    assign bus.k         = k_c;
    assign bus.err       = err_q;
    assign bus.errcnt    = errcnt_q;
endmodule

// File: tb/tb_jk_excitation_driver.sv
// Bench for jk_excitation_driver: three instances (N=8 set/reset, N=8 toggle,
// N=16 set/reset), each closing the loop through a JK flip-flop model whose Q can be
// ideal, stuck at 0, stuck at 1 or random. A cycle-count reference model predicts
// every output on every cycle; directed cases pin the model with literal values.
module tb_jk_excitation_driver;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst      [3];
    logic        pv       [3];
    logic [15:0] pat_d    [3];
    logic [1:0]  mode     [3];   // 0 ideal FF, 1 stuck 0, 2 stuck 1, 3 random
    logic        rq       [3];
    logic        ff_clr;
    logic        q        [3];
    logic        qfb      [3];

    logic        ready_o  [3];
    logic        j_o      [3];
    logic        k_o      [3];
    logic        busy_o   [3];
    logic        done_o   [3];
    logic        err_o    [3];
    logic [3:0]  errcnt_o [3];

    int checks = 0;
    int passed = 0;

    jk_excitation_driver_if #(.N(8))  bus0 ();
    jk_excitation_driver_if #(.N(8))  bus1 ();
    jk_excitation_driver_if #(.N(16)) bus2 ();

    assign bus0.pat = pat_d[0][7:0];
    assign bus1.pat = pat_d[1][7:0];
    assign bus2.pat = pat_d[2];
    assign bus0.pat_valid = pv[0];
    assign bus1.pat_valid = pv[1];
    assign bus2.pat_valid = pv[2];
    assign bus0.qfb = qfb[0];
    assign bus1.qfb = qfb[1];
    assign bus2.qfb = qfb[2];

    assign ready_o[0] = bus0.pat_ready;  assign ready_o[1] = bus1.pat_ready;  assign ready_o[2] = bus2.pat_ready;
    assign j_o[0] = bus0.j;              assign j_o[1] = bus1.j;              assign j_o[2] = bus2.j;
    assign k_o[0] = bus0.k;              assign k_o[1] = bus1.k;              assign k_o[2] = bus2.k;
    assign busy_o[0] = bus0.busy;        assign busy_o[1] = bus1.busy;        assign busy_o[2] = bus2.busy;
    assign done_o[0] = bus0.done;        assign done_o[1] = bus1.done;        assign done_o[2] = bus2.done;
    assign err_o[0] = bus0.err;          assign err_o[1] = bus1.err;          assign err_o[2] = bus2.err;
    assign errcnt_o[0] = bus0.errcnt;    assign errcnt_o[1] = bus1.errcnt;    assign errcnt_o[2] = bus2.errcnt;

    jk_excitation_driver #(.N(8),  .TOGGLE_MODE(1'b0)) dut0 (.clk(clk), .reset(rst[0]), .bus(bus0));
    jk_excitation_driver #(.N(8),  .TOGGLE_MODE(1'b1)) dut1 (.clk(clk), .reset(rst[1]), .bus(bus1));
    jk_excitation_driver #(.N(16), .TOGGLE_MODE(1'b0)) dut2 (.clk(clk), .reset(rst[2]), .bus(bus2));

    function automatic int nof(input int i);
        return (i == 2) ? 16 : 8;
    endfunction

    function automatic bit tmof(input int i);
        return (i == 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // External JK flip-flops clocked by the same clock.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (ff_clr) begin
                q[i] <= 1'b0;
            end else begin
                case ({j_o[i], k_o[i]})
                    2'b10:   q[i] <= 1'b1;
                    2'b01:   q[i] <= 1'b0;
                    2'b11:   q[i] <= ~q[i];
                    default: q[i] <= q[i];
                endcase
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            qfb[i] = 1'b0;
            case (mode[i])
                2'd0:    qfb[i] = q[i];
                2'd1:    qfb[i] = 1'b0;
                2'd2:    qfb[i] = 1'b1;
                default: qfb[i] = rq[i];
            endcase
        end
    end

    // Reference model: cycle c (1..2N+1) after an accept; odd c <= 2N drive bit (c-1)/2,
    // even c <= 2N check bit c/2-1, c = 2N+1 is the done cycle.
    bit          known [3];
    bit          act   [3];
    int          cyc   [3];
    logic [15:0] mpat  [3];
    int          mis   [3];
    bit          merr  [3];

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            automatic int         n  = nof(i);
            automatic logic       ej = 1'b0;
            automatic logic       ek = 1'b0;
            automatic logic       t;
            automatic logic [9:0] exp_v;
            automatic logic [9:0] act_v;
            if (act[i] && cyc[i] <= 2 * n && (cyc[i] % 2) == 1) begin
                t = mpat[i][(cyc[i] - 1) / 2];
                if (qfb[i] != t) begin
                    if (tmof(i)) {ej, ek} = 2'b11;
                    else         {ej, ek} = {t, ~t};
                end
            end
            exp_v = {!act[i], act[i] && cyc[i] <= 2 * n, act[i] && cyc[i] == 2 * n + 1,
                     ej, ek, merr[i], (mis[i] > 15) ? 4'd15 : 4'(mis[i])};
            act_v = {ready_o[i], busy_o[i], done_o[i], j_o[i], k_o[i], err_o[i], errcnt_o[i]};
            if (known[i]) chk($sformatf("outs%0d", i), {22'd0, act_v}, {22'd0, exp_v});
            if (rst[i]) begin
                known[i] = 1'b1;
                act[i]   = 1'b0;
                mis[i]   = 0;
                merr[i]  = 1'b0;
            end else if (!act[i]) begin
                if (pv[i]) begin
                    act[i]  = 1'b1;
                    cyc[i]  = 1;
                    mpat[i] = pat_d[i];
                    mis[i]  = 0;
                    merr[i] = 1'b0;
                end
            end else begin
                if ((cyc[i] % 2) == 0 && qfb[i] != mpat[i][cyc[i] / 2 - 1]) begin
                    mis[i]++;
                    merr[i] = 1'b1;
                end
                if (cyc[i] == 2 * n + 1) act[i] = 1'b0;
                else                     cyc[i]++;
            end
        end
    end

    // Offers one pattern from IDLE; returns edges from accept (counted as 1) to the DONE
    // cycle, and the J/K pairs seen in each drive cycle (first bit in the upper pair).
    task automatic run_pat(input int i, input logic [15:0] p, output int edges, output logic [31:0] jkseq);
        int e;
        logic [31:0] s;
        pat_d[i] = p;
        pv[i] = 1'b1;
        @(posedge clk);
        #1 pv[i] = 1'b0;
        e = 1;
        s = '0;
        while (e < 100) begin
            @(negedge clk);
            if (done_o[i]) break;
            if ((e % 2) == 1) s = {s[29:0], j_o[i], k_o[i]};
            @(posedge clk);
            #1;
            e++;
        end
        @(posedge clk);
        #1;
        edges = e;
        jkseq = s;
    endtask

    initial begin
        #300000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int edges;
        int dcy;
        int dones;
        logic [31:0] seq;

        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1;  pv[i] = 1'b0;  pat_d[i] = '0;  mode[i] = 2'd0;  rq[i] = 1'b0;
        end
        ff_clr = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) rst[i] = 1'b0;
        ff_clr = 1'b0;
        @(negedge clk);
        chk("rst_ready", ready_o[0], 1);
        chk("rst_busy", busy_o[0], 0);
        chk("rst_done", done_o[1], 0);
        chk("rst_jk", {j_o[1], k_o[1]}, 0);
        chk("rst_errcnt", errcnt_o[2], 0);
        @(posedge clk);
        #1;

        // Set/reset excitation, ideal flip-flop from Q=0; bits b0..b7 = 0,1,0,0,1,1,0,1.
        run_pat(0, 16'h00B2, edges, seq);
        chk("tm0_done_edges", edges, 17);
        chk("tm0_jk_seq", seq[15:0], 16'b00_10_01_00_10_00_01_10);
        chk("tm0_final_q", q[0], 1);
        chk("tm0_err", err_o[0], 0);
        chk("tm0_errcnt", errcnt_o[0], 0);

        // Toggle excitation: every change drives J=K=1.
        run_pat(1, 16'h00B2, edges, seq);
        chk("tm1_done_edges", edges, 17);
        chk("tm1_jk_seq", seq[15:0], 16'b00_11_11_00_11_00_11_11);
        chk("tm1_final_q", q[1], 1);
        chk("tm1_err", err_o[1], 0);

        // Q stuck at 0 against all-ones: every bit mismatches.
        mode[0] = 2'd1;
        run_pat(0, 16'h00FF, edges, seq);
        chk("stuck0_errcnt", errcnt_o[0], 8);
        chk("stuck0_err", err_o[0], 1);
        @(negedge clk);
        chk("stuck0_hold_errcnt", errcnt_o[0], 8);
        chk("stuck0_hold_err", err_o[0], 1);
        @(posedge clk);
        #1;

        // N=16, Q stuck at 1 against all-zeros: counter saturates at 15.
        mode[2] = 2'd2;
        run_pat(2, 16'h0000, edges, seq);
        chk("sat_done_edges", edges, 33);
        chk("sat_errcnt", errcnt_o[2], 15);
        chk("sat_err", err_o[2], 1);

        // Reset during the third CHECK discards the pattern without a DONE pulse.
        pat_d[0] = 16'h00FF;
        pv[0] = 1'b1;
        @(posedge clk);
        #1 pv[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        @(negedge clk);
        chk("mid_busy", busy_o[0], 1);
        chk("mid_errcnt", errcnt_o[0], 2);
        rst[0] = 1'b1;
        @(posedge clk);
        #1 rst[0] = 1'b0;
        @(negedge clk);
        chk("mid_rst_ready", ready_o[0], 1);
        chk("mid_rst_jk", {j_o[0], k_o[0]}, 0);
        chk("mid_rst_busy", busy_o[0], 0);
        chk("mid_rst_errcnt", errcnt_o[0], 0);
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done_o[0]) dones++;
        end
        chk("mid_rst_no_done", dones, 0);
        @(posedge clk);
        #1;

        // Reset and PAT_VALID at the same edge: nothing is captured.
        mode[2] = 2'd0;
        rst[2] = 1'b1;
        pv[2] = 1'b1;
        pat_d[2] = 16'hFFFF;
        @(posedge clk);
        #1;
        rst[2] = 1'b0;
        pv[2] = 1'b0;
        @(negedge clk);
        chk("rstpv_ready", ready_o[2], 1);
        chk("rstpv_busy", busy_o[2], 0);
        chk("rstpv_errcnt", errcnt_o[2], 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rstpv_busy2", busy_o[2], 0);
        @(posedge clk);
        #1;

        // PAT_VALID held high: next accept in the IDLE cycle right after DONE,
        // while PAT churns during BUSY (the model captures only at accept).
        pv[1] = 1'b1;
        pat_d[1] = 16'h005A;
        dcy = -1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (done_o[1] && dcy < 0) dcy = c;
            if (dcy >= 0 && c == dcy + 1) chk("b2b_ready", ready_o[1], 1);
            if (dcy >= 0 && c == dcy + 2) chk("b2b_busy", busy_o[1], 1);
            @(posedge clk);
            #1;
            if (busy_o[1]) pat_d[1] = 16'($urandom);
        end
        chk("b2b_done_seen", (dcy >= 0) ? 1 : 0, 1);
        pv[1] = 1'b0;

        // Randomized traffic: ideal flip-flops first, then random Q feedback.
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < 3; i++) begin
                mode[i]  = (c < 400) ? 2'd0 : 2'd3;
                rq[i]    = 1'($urandom);
                pv[i]    = ($urandom_range(0, 3) != 0);
                pat_d[i] = 16'($urandom);
                rst[i]   = ($urandom_range(0, 99) == 0);
            end
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b0;
            pv[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
